sipo_deserializer: RTL and testbench

Serial-in, parallel-out receiver. It is the receive end of the team's LSB-first right-shift PISO link. It gathers N serial bits, qualified by serial_valid, into a word. Each completed word goes into a double-buffered output register with a valid/ready handshake, so the next word can be collected while the downstream consumer is still stalled.

---
 rtl/sipo_deserializer.sv | 127 ++++++++++++
 tb/tb_sipo_deserializer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deserializer
// Description : Serial-in, parallel-out receiver for an LSB-first serial link.
//               It collects N qualified serial bits into a word and hands each
//               word to a double-buffered holding register with a valid/ready
//               handshake. A word that completes while the holding register is
//               full and stalled is dropped, and a sticky overrun flag is set.
//               Optional feature macro SIPO_PARITY_EN: each frame carries one
//               trailing even-parity bit, checked and reported in o_parity_err.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_deserializer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_serial_in,
    input  logic         i_serial_valid,
    input  logic         i_clear,
    output logic [N-1:0] o_data_out,
    output logic         o_data_valid,
    input  logic         i_data_ready,
    output logic         o_overrun,
    output logic         o_parity_err
);

    localparam int CNT_W = $clog2(N + 1);

`ifdef SIPO_PARITY_EN
    // Counter index of the trailing parity bit
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N);
`else
    // Counter index of the last data bit
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N - 1);
`endif

    logic [N-1:0]     r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_data;
    logic             r_valid;
    logic             r_overrun;

    logic             w_accept;
    logic             w_shift_en;
    logic             w_complete;
    logic             w_load;
    logic             w_drop;
    logic [N-1:0]     w_word;

    // Decode bit acceptance, word completion and what happens to a finished word
    always_comb begin
        w_accept   = i_serial_valid && !i_clear;
        w_complete = w_accept && (r_cnt == c_LAST);
`ifdef SIPO_PARITY_EN
        // The parity bit is checked but never shifted into the data register
        w_shift_en = w_accept && (r_cnt != c_LAST);
        w_word     = r_shift;
`else
        w_shift_en = w_accept;
        w_word     = {i_serial_in, r_shift[N-1:1]};
`endif
        // A finished word is taken if the holding register is empty or draining
        w_load     = w_complete && (!r_valid || i_data_ready);
        w_drop     = w_complete && r_valid && !i_data_ready;
    end

    // Shift register and bit counter; clear discards the partial word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            if (w_shift_en) begin
                r_shift <= {i_serial_in, r_shift[N-1:1]};
            end
            r_cnt <= w_complete ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Holding register, valid/ready handshake and sticky overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
            end else if (r_valid && i_data_ready) begin
                r_valid <= 1'b0;
            end
            if (i_clear) begin
                r_overrun <= 1'b0;
            end else if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

`ifdef SIPO_PARITY_EN
    logic r_parity_err;

    // Parity result travels with the word it belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else if (w_load) begin
            r_parity_err <= ^{r_shift, i_serial_in};
        end
    end

    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

    assign o_data_out   = r_data;
    assign o_data_valid = r_valid;
    assign o_overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_deserializer
// Description : Self-checking bench for sipo_deserializer. Directed scenarios
//               plus randomized traffic, compared each cycle against a
//               frame-level reference model built on a bit queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deserializer;

    localparam int N = 4;
`ifdef SIPO_PARITY_EN
    localparam int FRAME = N + 1;
`else
    localparam int FRAME = N;
`endif

    logic         clk;
    logic         rst;
    logic         i_serial_in;
    logic         i_serial_valid;
    logic         i_clear;
    logic [N-1:0] o_data_out;
    logic         o_data_valid;
    logic         i_data_ready;
    logic         o_overrun;
    logic         o_parity_err;

    int n_checks;
    int n_errors;

    // Reference model state
    int           m_bits[$];
    logic [N-1:0] m_data;
    logic         m_valid;
    logic         m_ovr;
    logic         m_perr;

    sipo_deserializer #(.N(N)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .i_serial_in    (i_serial_in),
        .i_serial_valid (i_serial_valid),
        .i_clear        (i_clear),
        .o_data_out     (o_data_out),
        .o_data_valid   (o_data_valid),
        .i_data_ready   (i_data_ready),
        .o_overrun      (o_overrun),
        .o_parity_err   (o_parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_perr  = 1'b0;
    endtask

    // One clock edge of the frame-level model
    task automatic model_edge(input logic sv, input logic sin, input logic clr, input logic rdy);
        logic         done;
        logic [N-1:0] word;
        logic         par;
        done = 1'b0;
        if (clr) begin
            m_bits.delete();
            m_ovr = 1'b0;
        end else if (sv) begin
            m_bits.push_back(int'(sin));
            if (m_bits.size() == FRAME) done = 1'b1;
        end
        if (done) begin
            word = '0;
            par  = 1'b0;
            for (int i = 0; i < FRAME; i++) begin
                if (i < N && m_bits[i] != 0) word = word + N'(1 << i);
                par = par ^ (m_bits[i] != 0);
            end
            m_bits.delete();
            if (!m_valid || rdy) begin
                m_data  = word;
                m_valid = 1'b1;
`ifdef SIPO_PARITY_EN
                m_perr  = par;
`endif
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".data"},  32'(o_data_out),   32'(m_data));
        check({tag, ".valid"}, 32'(o_data_valid), 32'(m_valid));
        check({tag, ".ovr"},   32'(o_overrun),    32'(m_ovr));
        check({tag, ".perr"},  32'(o_parity_err), 32'(m_perr));
    endtask

    // Drive inputs, take one edge, update the model, compare just after the edge
    task automatic step(input logic sv, input logic sin, input logic clr, input logic rdy, input string tag);
        i_serial_valid = sv;
        i_serial_in    = sin;
        i_clear        = clr;
        i_data_ready   = rdy;
        @(posedge clk);
        model_edge(sv, sin, clr, rdy);
        #1;
        compare_all(tag);
    endtask

    task automatic send_word(input logic [N-1:0] w, input logic rdy, input string tag);
        logic par;
        par = ^w;
        for (int i = 0; i < N; i++) step(1'b1, w[i], 1'b0, rdy, tag);
`ifdef SIPO_PARITY_EN
        step(1'b1, par, 1'b0, rdy, tag);
`endif
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        i_serial_valid = 1'b0;
        i_serial_in    = 1'b0;
        i_clear        = 1'b0;
        i_data_ready   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] vpat;
        logic [N-1:0] w6;
        int bi;
        n_checks = 0;
        n_errors = 0;

        // Reset state
        do_reset();
        compare_all("reset");
        check("reset.valid0", 32'(o_data_valid), 32'd0);

        // Single word 1,0,1,1 -> 0xD, valid exactly one cycle
        send_word(4'hD, 1'b1, "t1");
        check("t1.word", 32'(o_data_out), 32'hD);
        check("t1.valid", 32'(o_data_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, "t1.idle");
        check("t1.valid_drop", 32'(o_data_valid), 32'd0);

        // Back-to-back 0xA then 0x5
        send_word(4'hA, 1'b1, "t2a");
        check("t2.wordA", 32'(o_data_out), 32'hA);
        send_word(4'h5, 1'b1, "t2b");
        check("t2.word5", 32'(o_data_out), 32'h5);
        check("t2.ovr", 32'(o_overrun), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, "t2.idle");

        // Stalled consumer: 0x3 held, 0xC dropped
        send_word(4'h3, 1'b0, "t3a");
        send_word(4'hC, 1'b0, "t3b");
        check("t3.held", 32'(o_data_out), 32'h3);
        check("t3.ovr", 32'(o_overrun), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, "t3.xfer");
        check("t3.valid_after", 32'(o_data_valid), 32'd0);
        check("t3.ovr_sticky", 32'(o_overrun), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1, "t3.clear");
        check("t3.ovr_cleared", 32'(o_overrun), 32'd0);

        // Partial word, clear (with a bit in the same cycle), then 0x9
        step(1'b1, 1'b1, 1'b0, 1'b1, "t4.p0");
        step(1'b1, 1'b1, 1'b0, 1'b1, "t4.p1");
        step(1'b1, 1'b1, 1'b1, 1'b1, "t4.clr");
        send_word(4'h9, 1'b1, "t4");
        check("t4.word", 32'(o_data_out), 32'h9);
        check("t4.ovr", 32'(o_overrun), 32'd0);

        // Asynchronous reset mid-word, outputs zero before any edge
        step(1'b1, 1'b1, 1'b0, 1'b0, "t4r.p0");
        step(1'b1, 1'b0, 1'b0, 1'b0, "t4r.p1");
        i_serial_valid = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("t4r.data", 32'(o_data_out), 32'd0);
        check("t4r.valid", 32'(o_data_valid), 32'd0);
        check("t4r.ovr", 32'(o_overrun), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_word(4'h7, 1'b1, "t4r");
        check("t4r.word", 32'(o_data_out), 32'h7);

        // Gapped valid pattern 1,0,0,1,1,0,1 carrying 0x6
        vpat = 7'b1011001;
        w6   = 4'h6;
        bi   = 0;
        for (int i = 0; i < 7; i++) begin
            if (vpat[i]) begin
                step(1'b1, w6[bi], 1'b0, 1'b1, "t5");
                bi++;
            end else begin
                step(1'b0, 1'b1, 1'b0, 1'b1, "t5");
            end
        end
`ifdef SIPO_PARITY_EN
        step(1'b1, ^w6, 1'b0, 1'b1, "t5.par");
`endif
        check("t5.word", 32'(o_data_out), 32'h6);
        check("t5.valid", 32'(o_data_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, "t5.idle");

`ifdef SIPO_PARITY_EN
        // Good parity then bad parity on 0xB
        for (int i = 0; i < N; i++) step(1'b1, 1'((4'hB >> i) & 1), 1'b0, 1'b1, "t6a");
        step(1'b1, 1'b1, 1'b0, 1'b1, "t6a.par");
        check("t6a.word", 32'(o_data_out), 32'hB);
        check("t6a.perr", 32'(o_parity_err), 32'd0);
        for (int i = 0; i < N; i++) step(1'b1, 1'((4'hB >> i) & 1), 1'b0, 1'b1, "t6b");
        step(1'b1, 1'b0, 1'b0, 1'b1, "t6b.par");
        check("t6b.word", 32'(o_data_out), 32'hB);
        check("t6b.valid", 32'(o_data_valid), 32'd1);
        check("t6b.perr", 32'(o_parity_err), 32'd1);
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            step(logic'($urandom_range(0, 9) < 7),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 49) == 0),
                 logic'($urandom_range(0, 1)),
                 "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
